// File: rtl/truth_table_extractor.sv
// Sweeps all eight input combinations of a 3-input logic block and records its response
// as an 8-bit truth-table code, then compares it against an expected code.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | inputs parked at 000, waiting for start
// WAIT   | current vector applied, settle counter running down to 0
// SAMPLE | one cycle; dut_out captured into working bit idx at its end
// DONE   | one-cycle done pulse; table_code/match already updated

module truth_table_extractor #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expect_code,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_code,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

    state_t     state;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic [7:0] work;
    logic [7:0] exp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= 8'd0;
            work       <= 8'd0;
            exp_q      <= 8'd0;
            table_code <= 8'd0;
            match      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dut_in1    <= 1'b0;
            dut_in2    <= 1'b0;
            dut_in3    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q                       <= expect_code;
                        idx                         <= 3'd0;
                        work                        <= 8'd0;
                        cnt                         <= CNT_LOAD;
                        busy                        <= 1'b1;
                        {dut_in1, dut_in2, dut_in3} <= 3'b000;
                        state                       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    work[idx] <= dut_out;
                    if (idx == 3'd7) begin
                        // final sample goes straight into the published code so it is never partial
                        table_code                  <= {dut_out, work[6:0]};
                        match                       <= ({dut_out, work[6:0]} == exp_q);
                        busy                        <= 1'b0;
                        done                        <= 1'b1;
                        {dut_in1, dut_in2, dut_in3} <= 3'b000;
                        state                       <= DONE;
                    end else begin
                        idx                         <= idx + 3'd1;
                        {dut_in1, dut_in2, dut_in3} <= idx + 3'd1;
                        cnt                         <= CNT_LOAD;
                        state                       <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor: three instances (SETTLE=2, 1, 4) driving
// behavioural models of the logic under test, checked with immediate assertions.

module tb_truth_table_extractor;

    logic       clk;
    logic       reset;
    logic [7:0] expect_code;

    logic       start2, start1, start4;
    logic       a2, b2, c2, out2, busy2, done2, match2;
    logic       a1, b1, c1, out1, busy1, done1, match1;
    logic       a4, b4, c4, out4, busy4, done4, match4;
    logic [7:0] code2, code1, code4;

    logic [7:0] func2;
    logic [7:0] funcd;
    logic [2:0] p1_1, p1_2, p1_3;
    logic [2:0] p4_1, p4_2, p4_3;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational model for the SETTLE=2 instance
    assign out2 = func2[{a2, b2, c2}];

    // Models whose output follows the inputs three cycles late
    always @(posedge clk) begin
        p1_1 <= {a1, b1, c1};
        p1_2 <= p1_1;
        p1_3 <= p1_2;
        p4_1 <= {a4, b4, c4};
        p4_2 <= p4_1;
        p4_3 <= p4_2;
    end
    assign out1 = funcd[p1_3];
    assign out4 = funcd[p4_3];

    truth_table_extractor u2 (
        .clk(clk), .reset(reset), .start(start2), .expect_code(expect_code),
        .dut_in1(a2), .dut_in2(b2), .dut_in3(c2), .dut_out(out2),
        .busy(busy2), .done(done2), .table_code(code2), .match(match2)
    );

    truth_table_extractor #(.SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .expect_code(expect_code),
        .dut_in1(a1), .dut_in2(b1), .dut_in3(c1), .dut_out(out1),
        .busy(busy1), .done(done1), .table_code(code1), .match(match1)
    );

    truth_table_extractor #(.SETTLE(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .expect_code(expect_code),
        .dut_in1(a4), .dut_in2(b4), .dut_in3(c4), .dut_out(out4),
        .busy(busy4), .done(done4), .table_code(code4), .match(match4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int w);
        if (w == 1) return done1;
        if (w == 4) return done4;
        return done2;
    endfunction

    // Counts edges after the accepting edge until done is seen (bounded)
    task automatic wait_done(input int w, output int n);
        n = 0;
        while (n < 200) begin
            tick;
            n++;
            if (done_of(w) === 1'b1) break;
        end
    endtask

    int n;
    int pulses;

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        start2      = 1'b0;
        start1      = 1'b0;
        start4      = 1'b0;
        expect_code = 8'h00;
        func2       = 8'hEF;
        funcd       = 8'hEF;

        // Reset state
        #22;
        check("rst_busy",  32'(busy2), 32'd0);
        check("rst_done",  32'(done2), 32'd0);
        check("rst_match", 32'(match2), 32'd0);
        check("rst_code",  32'(code2), 32'h00);
        check("rst_din",   32'({a2, b2, c2}), 32'd0);

        tick;
        reset = 1'b0;

        // 0xEF function, first start accepted on the first edge after reset
        expect_code = 8'hEF;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check("first_accept_busy", 32'(busy2), 32'd1);
        wait_done(2, n);
        check("ef_latency", 32'(n), 32'd24);
        check("ef_code",    32'(code2), 32'hEF);
        check("ef_match",   32'(match2), 32'd1);
        check("ef_busy_in_done", 32'(busy2), 32'd0);
        tick;
        check("ef_done_one_cycle", 32'(done2), 32'd0);
        check("ef_code_hold", 32'(code2), 32'hEF);

        // Constant-1 model, input sequence 000..111 with three cycles each
        func2 = 8'hFF;
        expect_code = 8'h80;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            check("seq_din",  32'({a2, b2, c2}), 32'(c / 3));
            check("seq_busy", 32'(busy2), 32'd1);
            tick;
        end
        check("ones_done",  32'(done2), 32'd1);
        check("ones_code",  32'(code2), 32'hFF);
        check("ones_match", 32'(match2), 32'd0);

        // Re-pulsing start and changing expect_code while busy
        func2 = 8'hEF;
        expect_code = 8'hEF;
        tick;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        n = 0;
        while (n < 200) begin
            if (n == 4 || n == 9) begin
                start2 = 1'b1;
                expect_code = 8'h00;
            end else begin
                start2 = 1'b0;
            end
            tick;
            n++;
            if (done2 === 1'b1) break;
        end
        start2 = 1'b0;
        check("restart_latency", 32'(n), 32'd24);
        check("restart_code",    32'(code2), 32'hEF);
        check("restart_match",   32'(match2), 32'd1);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (done2 === 1'b1 || busy2 === 1'b1) pulses++;
        end
        check("restart_single_done", 32'(pulses), 32'd0);
        expect_code = 8'hEF;

        // Asynchronous reset in the middle of a sweep
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        repeat (12) tick;
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy",  32'(busy2), 32'd0);
        check("abort_code",  32'(code2), 32'h00);
        check("abort_match", 32'(match2), 32'd0);
        check("abort_din",   32'({a2, b2, c2}), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (done2 === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        reset = 1'b0;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        wait_done(2, n);
        check("after_abort_latency", 32'(n), 32'd24);
        check("after_abort_code",    32'(code2), 32'hEF);
        check("after_abort_match",   32'(match2), 32'd1);

        // Slow logic: SETTLE=1 samples the previous vector's response
        tick;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        wait_done(1, n);
        check("s1_latency", 32'(n), 32'd16);
        check("s1_code",    32'(code1), 32'hDF);
        check("s1_match",   32'(match1), 32'd0);

        // Slow logic with SETTLE=4 settles properly
        tick;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        wait_done(4, n);
        check("s4_latency", 32'(n), 32'd40);
        check("s4_code",    32'(code4), 32'hEF);
        check("s4_match",   32'(match4), 32'd1);

        // Start held through DONE is ignored there, taken in the following IDLE cycle
        func2 = 8'h96;
        expect_code = 8'h96;
        tick;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        wait_done(2, n);
        check("xor_latency", 32'(n), 32'd24);
        check("xor_code",    32'(code2), 32'h96);
        start2 = 1'b1;
        tick;
        check("start_in_done_ignored", 32'(busy2), 32'd0);
        tick;
        start2 = 1'b0;
        check("start_in_idle_accepted", 32'(busy2), 32'd1);
        wait_done(2, n);
        check("idle_start_latency", 32'(n), 32'd24);
        check("idle_start_match",   32'(match2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
